// File: rtl/riscv_lsu.sv
// Load-store unit: turns core byte/half/word accesses into word-addressed memory
// transactions with byte enables, and formats returned load data for the core.
module riscv_lsu (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        core_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  size_q, size_d;
  logic        we_q, we_d;

  logic        acc_err;
  logic [3:0]  be_st;
  logic [31:0] wd_rep;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] ld_fmt;
  logic        req;

  always_comb begin
    acc_err = 1'b0;
    case (core_size_i)
      LDST_B, LDST_BU: acc_err = 1'b0;
      LDST_H, LDST_HU: acc_err = core_addr_i[0];
      LDST_W:          acc_err = |core_addr_i[1:0];
      default:         acc_err = 1'b1;
    endcase
  end

  // Store lanes: data is replicated so whichever lane the enables select holds it.
  always_comb begin
    be_st  = 4'b1111;
    wd_rep = core_wd_i;
    case (core_size_i[1:0])
      2'd0: begin
        be_st  = 4'b0001 << core_addr_i[1:0];
        wd_rep = {4{core_wd_i[7:0]}};
      end
      2'd1: begin
        be_st  = core_addr_i[1] ? 4'b1100 : 4'b0011;
        wd_rep = {2{core_wd_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_byte = mem_rd_i[{off_q, 3'b000} +: 8];
    rd_half = off_q[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
    case (size_q)
      LDST_B:  ld_fmt = {{24{rd_byte[7]}}, rd_byte};
      LDST_BU: ld_fmt = {24'h0, rd_byte};
      LDST_H:  ld_fmt = {{16{rd_half[15]}}, rd_half};
      LDST_HU: ld_fmt = {16'h0, rd_half};
      default: ld_fmt = mem_rd_i;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    off_d        = off_q;
    size_d       = size_q;
    we_d         = we_q;
    req          = 1'b0;
    core_stall_o = 1'b0;
    core_err_o   = 1'b0;
    core_rd_o    = 32'h0;
    case (state_q)
      S_IDLE: begin
        if (core_req_i) begin
          if (acc_err) begin
            core_err_o = 1'b1;
          end else begin
            req          = 1'b1;
            core_stall_o = 1'b1;
            off_d        = core_addr_i[1:0];
            size_d       = core_size_i;
            we_d         = core_we_i;
            state_d      = mem_ready_i ? S_RESP : S_REQ;
          end
        end
      end
      S_REQ: begin
        req          = 1'b1;
        core_stall_o = 1'b1;
        if (mem_ready_i) state_d = S_RESP;
      end
      S_RESP: begin
        // core_req_i is still the instruction just served, so it is not re-accepted here.
        state_d = S_IDLE;
        if (!we_q) core_rd_o = ld_fmt;
      end
      default: state_d = S_IDLE;
    endcase
    if (rst_i) begin
      req          = 1'b0;
      core_stall_o = 1'b0;
      core_err_o   = 1'b0;
      core_rd_o    = 32'h0;
    end
  end

  assign mem_req_o  = req;
  assign mem_we_o   = req & core_we_i;
  assign mem_be_o   = (req && core_we_i) ? be_st : 4'b0000;
  assign mem_addr_o = core_addr_i;
  assign mem_wd_o   = wd_rep;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      off_q   <= 2'd0;
      size_q  <= 3'd0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      size_q  <= size_d;
      we_q    <= we_d;
    end
  end

endmodule

// File: tb/tb_riscv_lsu.sv
// Self-checking bench for riscv_lsu: directed test-plan cases plus randomized
// back-to-back accesses checked against an arithmetic reference model.
module tb_riscv_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req;
  logic        core_we;
  logic [2:0]  core_size;
  logic [31:0] core_addr;
  logic [31:0] core_wd;
  logic [31:0] core_rd;
  logic        core_stall;
  logic        core_err;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;
  logic        mem_ready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  riscv_lsu dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .core_req_i   (core_req),
    .core_we_i    (core_we),
    .core_size_i  (core_size),
    .core_addr_i  (core_addr),
    .core_wd_i    (core_wd),
    .core_rd_o    (core_rd),
    .core_stall_o (core_stall),
    .core_err_o   (core_err),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .mem_be_o     (mem_be),
    .mem_addr_o   (mem_addr),
    .mem_wd_o     (mem_wd),
    .mem_rd_i     (mem_rd),
    .mem_ready_i  (mem_ready)
  );

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [2:0] s);
    return 1 << s[1:0];
  endfunction

  function automatic logic exp_err(input logic [2:0] s, input logic [31:0] a);
    if (s == 3'd3 || s == 3'd6 || s == 3'd7) return 1'b1;
    return (int'(a[1:0]) % nbytes(s)) != 0;
  endfunction

  function automatic logic [3:0] exp_be(input logic we, input logic [2:0] s, input logic [31:0] a);
    logic [7:0] m;
    if (!we) return 4'b0000;
    m = 8'((1 << nbytes(s)) - 1) << a[1:0];
    return m[3:0];
  endfunction

  function automatic logic [31:0] exp_wd(input logic [2:0] s, input logic [31:0] wd);
    logic [31:0] r;
    r = 32'h0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nbytes(s)) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [2:0] s, input logic [31:0] a, input logic [31:0] rd);
    logic [63:0] v, mask;
    int w;
    w    = 8 * nbytes(s);
    v    = {32'h0, rd} >> (8 * int'(a[1:0]));
    mask = (64'd1 << w) - 64'd1;
    v    = v & mask;
    if (!s[2] && w < 32 && v[w-1]) v = v | ~mask;
    return v[31:0];
  endfunction

  // Drives one legal access starting in an IDLE cycle (entered at posedge+1),
  // with k edges of mem_ready low; returns in the following IDLE cycle with
  // core_req still asserted so the caller can chain a back-to-back request.
  task automatic run_access(input string nm, input logic we, input logic [2:0] s,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] rdata, input int k,
                            output logic [31:0] got_rd);
    logic [31:0] erd;
    core_req  = 1'b1;
    core_we   = we;
    core_size = s;
    core_addr = a;
    core_wd   = wd;
    mem_ready = (k == 0);
    mem_rd    = $urandom;
    for (int c = 0; c <= k; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        mem_ready = (c == k);
        mem_rd    = $urandom;
      end
      #1;
      total++;
      if (mem_req !== 1'b1 || core_stall !== 1'b1 || core_err !== 1'b0 || core_rd !== 32'h0) begin
        bad++;
        $display("FAIL %s req-cycle%0d ctl: req=%b stall=%b err=%b rd=%h, want 1 1 0 00000000",
                 nm, c, mem_req, core_stall, core_err, core_rd);
      end
      total++;
      if (mem_we !== we || mem_be !== exp_be(we, s, a) || mem_addr !== a || mem_wd !== exp_wd(s, wd)) begin
        bad++;
        $display("FAIL %s req-cycle%0d mem: we=%b be=%b addr=%h wd=%h, want %b %b %h %h",
                 nm, c, mem_we, mem_be, mem_addr, mem_wd, we, exp_be(we, s, a), a, exp_wd(s, wd));
      end
    end
    @(posedge clk); #1;
    mem_rd    = rdata;
    mem_ready = $urandom_range(0, 1);
    #1;
    erd    = we ? 32'h0 : exp_rd(s, a, rdata);
    got_rd = core_rd;
    total++;
    if (core_stall !== 1'b0 || mem_req !== 1'b0 || mem_we !== 1'b0 || mem_be !== 4'b0000 ||
        core_err !== 1'b0 || core_rd !== erd) begin
      bad++;
      $display("FAIL %s resp: stall=%b req=%b we=%b be=%b err=%b rd=%h, want 0 0 0 0000 0 %h",
               nm, core_stall, mem_req, mem_we, mem_be, core_err, core_rd, erd);
    end
    @(posedge clk); #1;
  endtask

  task automatic go_idle(input string nm);
    core_req = 1'b0;
    mem_rd   = $urandom;
    #1;
    total++;
    if (mem_req !== 1'b0 || core_stall !== 1'b0 || core_err !== 1'b0 || core_rd !== 32'h0) begin
      bad++;
      $display("FAIL %s idle: req=%b stall=%b err=%b rd=%h, want 0 0 0 00000000",
               nm, mem_req, core_stall, core_err, core_rd);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; core_req = 1'b1; core_we = 1'b1; core_size = 3'd7;
    core_addr = 32'h3; core_wd = 32'hFFFF_FFFF; mem_rd = 32'hFFFF_FFFF; mem_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if (mem_req !== 1'b0 || core_stall !== 1'b0 || core_err !== 1'b0 || core_rd !== 32'h0 ||
        mem_be !== 4'b0000 || mem_we !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold: req=%b stall=%b err=%b rd=%h be=%b we=%b, want all zero",
               mem_req, core_stall, core_err, core_rd, mem_be, mem_we);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    go_idle("reset_release");
  endtask

  task automatic test_store_word();
    logic [31:0] r;
    run_access("store_w", 1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, 32'h0, 0, r);
    go_idle("store_w");
  endtask

  task automatic test_store_byte_half();
    logic [31:0] r;
    core_req = 1'b1; core_we = 1'b1; core_size = 3'd0; core_addr = 32'h13;
    core_wd = 32'h0000_00A5; mem_ready = 1'b1; #1;
    total++;
    if (mem_be !== 4'b1000 || mem_wd !== 32'hA5A5_A5A5) begin
      bad++;
      $display("FAIL store_b_plan: be=%b wd=%h, want 1000 a5a5a5a5", mem_be, mem_wd);
    end
    run_access("store_b", 1'b1, 3'd0, 32'h13, 32'h0000_00A5, 32'h0, 0, r);
    core_size = 3'd1; core_addr = 32'h12; core_wd = 32'h0000_1234; #1;
    total++;
    if (mem_be !== 4'b1100 || mem_wd !== 32'h1234_1234) begin
      bad++;
      $display("FAIL store_h_plan: be=%b wd=%h, want 1100 12341234", mem_be, mem_wd);
    end
    run_access("store_h", 1'b1, 3'd1, 32'h12, 32'h0000_1234, 32'h0, 1, r);
    go_idle("store_bh");
  endtask

  task automatic test_load_ext();
    logic [2:0]  sz  [5] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
    logic [31:0] ad  [5] = '{32'h102, 32'h102, 32'h102, 32'h100, 32'h100};
    logic [31:0] exp [5] = '{32'hFFFF_FFFF, 32'h0000_00FF, 32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01};
    logic [31:0] r;
    for (int i = 0; i < 5; i++) begin
      run_access("load_ext", 1'b0, sz[i], ad[i], $urandom, 32'h80FF_7F01, 0, r);
      total++;
      if (r !== exp[i]) begin
        bad++;
        $display("FAIL load_ext_plan[%0d]: rd=%h, want %h", i, r, exp[i]);
      end
    end
    go_idle("load_ext");
  endtask

  task automatic test_wait_states();
    logic [31:0] r;
    run_access("wait3", 1'b1, 3'd1, 32'h46, 32'hCAFE_5A5A, 32'h0, 3, r);
    go_idle("wait3");
    run_access("wait2_ld", 1'b0, 3'd0, 32'h41, 32'h0, 32'h1234_8000, 2, r);
    go_idle("wait2_ld");
  endtask

  task automatic test_errors();
    logic [2:0]  sz [3] = '{3'd2, 3'd1, 3'd7};
    logic [31:0] ad [3] = '{32'h02, 32'h01, 32'h00};
    for (int i = 0; i < 3; i++) begin
      core_req = 1'b1; core_we = i[0]; core_size = sz[i]; core_addr = ad[i];
      mem_ready = 1'b1;
      for (int c = 0; c < 2; c++) begin
        #1;
        total++;
        if (core_err !== 1'b1 || mem_req !== 1'b0 || core_stall !== 1'b0 || mem_be !== 4'b0000) begin
          bad++;
          $display("FAIL err[%0d] cycle%0d: err=%b req=%b stall=%b be=%b, want 1 0 0 0000",
                   i, c, core_err, mem_req, core_stall, mem_be);
        end
        @(posedge clk); #1;
      end
    end
    go_idle("errors");
  endtask

  task automatic test_reset_in_req();
    core_req = 1'b1; core_we = 1'b0; core_size = 3'd2; core_addr = 32'h20;
    mem_ready = 1'b0; #1;
    @(posedge clk); #1;
    total++;
    if (mem_req !== 1'b1 || core_stall !== 1'b1) begin
      bad++;
      $display("FAIL rst_req_pre: req=%b stall=%b, want 1 1", mem_req, core_stall);
    end
    rst = 1'b1; #1;
    total++;
    if (mem_req !== 1'b0 || core_stall !== 1'b0 || mem_be !== 4'b0000) begin
      bad++;
      $display("FAIL rst_req_during: req=%b stall=%b be=%b, want 0 0 0000", mem_req, core_stall, mem_be);
    end
    @(posedge clk); #1;
    rst = 1'b0; core_req = 1'b0; mem_ready = 1'b1; mem_rd = 32'hFFFF_FFFF;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if (mem_req !== 1'b0 || core_stall !== 1'b0 || core_rd !== 32'h0) begin
        bad++;
        $display("FAIL rst_req_after%0d: req=%b stall=%b rd=%h, want 0 0 00000000",
                 c, mem_req, core_stall, core_rd);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  s;
    logic [31:0] a, r;
    for (int n = 0; n < 60; n++) begin
      s = 3'($urandom_range(0, 7));
      a = {$urandom_range(0, 32'h3FFF), 2'b00} | 32'($urandom_range(0, 3));
      if (exp_err(s, a)) begin
        core_req = 1'b1; core_we = $urandom_range(0, 1); core_size = s; core_addr = a;
        #1;
        total++;
        if (core_err !== 1'b1 || mem_req !== 1'b0 || core_stall !== 1'b0) begin
          bad++;
          $display("FAIL b2b_err s=%0d a=%h: err=%b req=%b stall=%b, want 1 0 0",
                   s, a, core_err, mem_req, core_stall);
        end
        @(posedge clk); #1;
      end else begin
        run_access("b2b", 1'($urandom_range(0, 1)), s, a, $urandom, $urandom,
                   $urandom_range(0, 3), r);
      end
    end
    go_idle("b2b");
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_store_byte_half();
    test_load_ext();
    test_wait_states();
    test_errors();
    test_reset_in_req();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
